qed_inst_gen: RTL and testbench
===============================

// Module: qed_inst_gen
// PURPOSE
//  Producer side of the QED instruction-constraint interface: emits a pseudo-random stream of
//  RV32I instructions that are legal under the constraint set (regs x0-x15, LW/SW base x0,
//  LW imm12<64, SW imm7<2, SW only after SIF commit, NOP = opcode 7'h7F). Drives the core's
//  instruction input in simulation benches in place of the formal tool's free input.
// PARAMETERS
//  SEED        32'h0000_0001  LFSR reset value; 0 is illegal, treated as 32'h1
//  MAX_INSTS   16'd256        random instructions emitted before draining
//  DRAIN_NOPS  8'd8           NOPs emitted after MAX_INSTS, then done
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  en           in   1   start/continue generation; sampled in IDLE only
//  sif_commit   in   1   core SIF commit indicator; latched sticky into sif_seen
//  inst_ready   in   1   consumer accepts instruction this cycle
//  inst_valid   out  1   instruction holds a valid word
//  instruction  out  32  generated instruction
//  inst_count   out  16  random (non-drain) instructions accepted since reset
//  done         out  1   drain complete; sticky until rst
// BEHAVIOUR
//  - Reset: inst_valid=0, instruction=32'h0000_007F, inst_count=0, done=0, sif_seen=0,
//    lfsr=SEED, state=IDLE. rst overrides everything incl. a mid-handshake word (word dropped).
//  - LFSR: 32-bit Galois, taps 32'h8020_0003, shifts once per accepted word (valid&&ready).
//  - FSM: IDLE -(en)-> GEN: load word from lfsr, valid=1 next cycle (1-cycle latency).
//    GEN: on accept, inst_count++; if inst_count+1==MAX_INSTS -> DRAIN else next random word.
//    DRAIN: presents 7F NOPs; after DRAIN_NOPS accepts -> DONE. DONE: valid=0, done=1.
//    MAX_INSTS==0: IDLE goes straight to DRAIN. DRAIN_NOPS==0: DRAIN skipped.
//  - Handshake: word and valid stable while valid&&!ready; new word the cycle after accept
//    (back-to-back allowed, no bubble). en ignored outside IDLE.
//  - sif_seen <= sif_seen | sif_commit every cycle.
//  - Class from next-lfsr[3:0]: 0-3 I, 4-7 R, 8 LW, 9 JAL, 10 LUI, 11 AUIPC, 12 SW, 13-15 NOP.
//    SW when !(sif_seen|sif_commit) at load time -> replaced by NOP (same LFSR step).
//  - Fields (L=lfsr): rd={0,L[15:12]}, rs1={0,L[11:8]}, rs2={0,L[19:16]}, f3=L[6:4].
//    I: op 13, imm12=L[31:20]; f3=001 -> [31:25]=0; f3=101 -> [31:25]=L[7]?7'h20:0.
//    R: op 33, [31:25]=7'h20 iff L[7] && f3 in {000,101}, else 0.
//    LW: op 03, f3=010, rs1=0, imm12={6'b0,L[21:16]}. SW: op 23, f3=010, rs1=0,
//    [31:25]={6'b0,L[20]}, [11:7]=L[25:21]. JAL: op 6F, [31:12]=L[31:12].
//    LUI op 37 / AUIPC op 17: [31:12]=L[31:12]. NOP: 32'h0000_007F.
//  - inst_count saturates at 16'hFFFF; drain NOPs and masked-SW NOPs: masked ones count,
//    drain ones do not.
// CONFIGURATION
//  INST_GEN_ASSERT_EN defined: embeds concurrent assertions on every valid word checking
//    reg index<16, LW/SW base x0 and imm limits, SW only with sif_seen, opcode in legal set,
//    and handshake stability (valid&&!ready |=> $stable(instruction) && valid).
//  Not defined: no assertions; functional RTL identical.
// TESTING
//  - rst held 3 cycles, en=0 -> valid=0, instruction=32'h7F, count=0, done=0 throughout.
//  - SEED=1, en=1, ready=1, sif_commit=0, MAX_INSTS=1000 -> zero words with opcode 23.
//  - Pulse sif_commit 1 cycle at cycle 50 -> opcode-23 words appear later, all rs1=0, imm<2.
//  - ready=0 for 10 cycles with valid=1 -> instruction unchanged; ready=1 -> next word +1 cycle.
//  - MAX_INSTS=4, DRAIN_NOPS=2, ready=1 -> 4 random, 2x 32'h7F, then valid=0, done=1, count=4.
//  - rst asserted while valid&&!ready mid-GEN -> next cycle reset values, LFSR back to SEED.

Source files
------------

// File: rtl/qed_inst_gen.sv
// Pseudo-random RV32I instruction producer for the QED constraint interface (valid/ready output).
// Optional embedded property checks are enabled by defining INST_GEN_ASSERT_EN.
module qed_inst_gen #(
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter logic [15:0] MAX_INSTS  = 16'd256,
    parameter logic [7:0]  DRAIN_NOPS = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sif_commit,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [15:0] inst_count,
    output logic        done
);
    // Handshake: a word transfers on any posedge where inst_valid && inst_ready; while
    // inst_valid && !inst_ready the word and inst_valid hold unchanged.
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] NOP      = 32'h0000_007F;

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  drain_q, drain_d;
    logic        done_q, done_d;
    logic        sif_seen_q, sif_seen_d;
    logic        accept, sif_ok;
    logic [31:0] lfsr_adv, gen_word;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] build_word(input logic [31:0] l, input logic sw_ok);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        rd  = {1'b0, l[15:12]};
        rs1 = {1'b0, l[11:8]};
        rs2 = {1'b0, l[19:16]};
        f3  = l[6:4];
        f7  = 7'h0;
        w   = NOP;
        case (l[3:0])
            4'd0, 4'd1, 4'd2, 4'd3: begin
                // Shift-immediates need a legal funct7 in the top of imm12.
                if (f3 == 3'b001)      f7 = 7'h00;
                else if (f3 == 3'b101) f7 = l[7] ? 7'h20 : 7'h00;
                else                   f7 = l[31:25];
                w = {f7, l[24:20], rs1, f3, rd, 7'h13};
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
                f7 = (l[7] && (f3 == 3'b000 || f3 == 3'b101)) ? 7'h20 : 7'h00;
                w  = {f7, rs2, rs1, f3, rd, 7'h33};
            end
            4'd8:  w = {6'b0, l[21:16], 5'd0, 3'b010, rd, 7'h03};
            4'd9:  w = {l[31:12], rd, 7'h6F};
            4'd10: w = {l[31:12], rd, 7'h37};
            4'd11: w = {l[31:12], rd, 7'h17};
            4'd12: if (sw_ok) w = {6'b0, l[20], rs2, 5'd0, 3'b010, l[25:21], 7'h23};
            default: w = NOP;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_EFF;
            word_q     <= NOP;
            valid_q    <= 1'b0;
            count_q    <= 16'd0;
            drain_q    <= 8'd0;
            done_q     <= 1'b0;
            sif_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            sif_seen_q <= sif_seen_d;
        end
    end

    always_comb begin
        accept     = valid_q && inst_ready;
        sif_ok     = sif_seen_q | sif_commit;
        lfsr_adv   = accept ? lfsr_step(lfsr_q) : lfsr_q;
        // Each word is drawn from the value one step ahead of the LFSR register.
        gen_word   = build_word(lfsr_step(lfsr_adv), sif_ok);
        state_d    = state_q;
        lfsr_d     = lfsr_adv;
        word_d     = word_q;
        valid_d    = valid_q;
        count_d    = count_q;
        drain_d    = drain_q;
        done_d     = done_q;
        sif_seen_d = sif_ok;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (MAX_INSTS != 16'd0) begin
                        state_d = S_GEN;
                        word_d  = gen_word;
                        valid_d = 1'b1;
                    end else if (DRAIN_NOPS != 8'd0) begin
                        state_d = S_DRAIN;
                        word_d  = NOP;
                        valid_d = 1'b1;
                        drain_d = 8'd0;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_GEN: begin
                if (accept) begin
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    if ({1'b0, count_q} + 17'd1 == {1'b0, MAX_INSTS}) begin
                        word_d  = NOP;
                        drain_d = 8'd0;
                        if (DRAIN_NOPS != 8'd0) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        word_d = gen_word;
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    if ({1'b0, drain_q} + 9'd1 == {1'b0, DRAIN_NOPS}) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 8'd1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        endcase
    end

    assign inst_valid  = valid_q;
    assign instruction = word_q;
    assign inst_count  = count_q;
    assign done        = done_q;

`ifdef INST_GEN_ASSERT_EN
    logic [6:0] a_op;
    assign a_op = word_q[6:0];

    a_stable: assert property (@(posedge clk) disable iff (rst)
        valid_q && !inst_ready |=> $stable(word_q) && valid_q);
    a_opcode: assert property (@(posedge clk) disable iff (rst)
        valid_q |-> a_op inside {7'h13, 7'h33, 7'h03, 7'h23, 7'h6F, 7'h37, 7'h17, 7'h7F});
    a_rd: assert property (@(posedge clk) disable iff (rst)
        valid_q && a_op inside {7'h13, 7'h33, 7'h03, 7'h6F, 7'h37, 7'h17} |-> !word_q[11]);
    a_rs1: assert property (@(posedge clk) disable iff (rst)
        valid_q && a_op inside {7'h13, 7'h33} |-> !word_q[19]);
    a_rs2: assert property (@(posedge clk) disable iff (rst)
        valid_q && a_op inside {7'h33, 7'h23} |-> !word_q[24]);
    a_lw: assert property (@(posedge clk) disable iff (rst)
        valid_q && a_op == 7'h03 |-> word_q[19:15] == 5'd0 && word_q[31:26] == 6'd0);
    a_sw: assert property (@(posedge clk) disable iff (rst)
        valid_q && a_op == 7'h23 |-> word_q[19:15] == 5'd0 && word_q[31:26] == 6'd0 && sif_seen_q);
`endif

endmodule

// File: tb/tb_qed_inst_gen.sv
// Directed bench for qed_inst_gen: reset values, long random run against a reference model,
// SW masking around a sif_commit pulse, stall/reset mid-handshake, drain and zero-length configs.
module tb_qed_inst_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // dut_a: long run
    logic        rst_a, en_a, sif_a, rdy_a;
    logic        va, da;
    logic [31:0] ia;
    logic [15:0] ca;
    // dut_b: short run with drain; dut_c: zero instructions and zero drain
    logic        rst_bc, en_b, rdy_b, en_c, rdy_c;
    logic        vb, db, vc, dc;
    logic [31:0] ib, ic;
    logic [15:0] cb, cc;

    qed_inst_gen #(.SEED(32'h1), .MAX_INSTS(16'd1000), .DRAIN_NOPS(8'd8)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .sif_commit(sif_a), .inst_ready(rdy_a),
        .inst_valid(va), .instruction(ia), .inst_count(ca), .done(da));
    qed_inst_gen #(.SEED(32'h1), .MAX_INSTS(16'd4), .DRAIN_NOPS(8'd2)) dut_b (
        .clk(clk), .rst(rst_bc), .en(en_b), .sif_commit(1'b0), .inst_ready(rdy_b),
        .inst_valid(vb), .instruction(ib), .inst_count(cb), .done(db));
    qed_inst_gen #(.SEED(32'h1), .MAX_INSTS(16'd0), .DRAIN_NOPS(8'd0)) dut_c (
        .clk(clk), .rst(rst_bc), .en(en_c), .sif_commit(1'b0), .inst_ready(rdy_c),
        .inst_valid(vc), .instruction(ic), .inst_count(cc), .done(dc));

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic        chk_word;
        logic [31:0] exp_word;
        logic [15:0] exp_count;
        logic        exp_done;
    } vec_t;
    vec_t tbl[10];

    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] l);
        logic [31:0] r;
        r = {1'b0, l[31:1]};
        if (l[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] m_build(input logic [31:0] l, input logic sw_ok);
        logic [31:0] w;
        logic [2:0]  f3;
        f3 = l[6:4];
        w  = 32'h7F;
        if (l[3:2] == 2'b00) begin
            w = {l[31:20], 1'b0, l[11:8], f3, 1'b0, l[15:12], 7'h13};
            if (f3 == 3'd1) w[31:25] = 7'h00;
            if (f3 == 3'd5) w[31:25] = l[7] ? 7'h20 : 7'h00;
        end else if (l[3:2] == 2'b01) begin
            w = {7'h00, 1'b0, l[19:16], 1'b0, l[11:8], f3, 1'b0, l[15:12], 7'h33};
            if (l[7] && (f3 == 3'd0 || f3 == 3'd5)) w[31:25] = 7'h20;
        end else if (l[3:0] == 4'd8) w = {6'd0, l[21:16], 8'h02, 1'b0, l[15:12], 7'h03};
        else if (l[3:0] == 4'd9)  w = {l[31:12], 1'b0, l[15:12], 7'h6F};
        else if (l[3:0] == 4'd10) w = {l[31:12], 1'b0, l[15:12], 7'h37};
        else if (l[3:0] == 4'd11) w = {l[31:12], 1'b0, l[15:12], 7'h17};
        else if (l[3:0] == 4'd12 && sw_ok)
            w = {6'd0, l[20], 1'b0, l[19:16], 8'h02, l[25:21], 7'h23};
        return w;
    endfunction

    initial begin
        logic [31:0] lfsr_m, m_word, held;
        logic        m_valid, sif_m, r, s;
        logic [15:0] m_count;
        int          sw_early, sw_late;

        // First words from SEED=1, worked by hand from the Galois steps.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h8020_0013, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h8020_0013, 16'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hC030_0013, 16'd1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h6010_0013, 16'd2, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hB020_0013, 16'd3, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'hB020_0013, 16'd3, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_007F, 16'd4, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_007F, 16'd4, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0,         16'd4, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0,         16'd4, 1'b1};

        rst_a = 1'b1; en_a = 1'b0; sif_a = 1'b0; rdy_a = 1'b0;
        rst_bc = 1'b1; en_b = 1'b0; rdy_b = 1'b0; en_c = 1'b0; rdy_c = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_valid", {31'd0, va}, 32'd0);
            check("rst_instr", ia, 32'h7F);
            check("rst_count", {16'd0, ca}, 32'd0);
            check("rst_done", {31'd0, da}, 32'd0);
        end
        rst_a = 1'b0; rst_bc = 1'b0;
        @(posedge clk); #1;
        check("idle_no_en_valid", {31'd0, va}, 32'd0);

        // Long run: model tracks every edge; sif_commit pulses at cycle 50, stall 100..109.
        lfsr_m = 32'h1; m_word = 32'h7F; m_valid = 1'b0; m_count = 16'd0; sif_m = 1'b0;
        sw_early = 0; sw_late = 0; held = 32'h0;
        en_a = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = (cyc >= 100 && cyc < 110) ? 1'b0 : ((cyc % 5) != 2);
            s = (cyc == 50);
            rdy_a = r; sif_a = s;
            if (!m_valid) begin
                m_word = m_build(m_step(lfsr_m), sif_m | s);
                m_valid = 1'b1;
            end else if (r) begin
                exp_q.push_back(m_word);
                lfsr_m = m_step(lfsr_m);
                m_count++;
                m_word = m_build(m_step(lfsr_m), sif_m | s);
            end
            sif_m = sif_m | s;
            @(posedge clk); #1;
            check("run_valid", {31'd0, va}, {31'd0, m_valid});
            check("run_instr", ia, m_word);
            check("run_count", {16'd0, ca}, {16'd0, m_count});
            if (cyc == 100) held = ia;
            if (cyc > 100 && cyc < 110) check("stall_hold", ia, held);
            if (va && ia[6:0] == 7'h23) begin
                if (cyc < 50) sw_early++;
                else sw_late++;
                check("sw_rs1", {27'd0, ia[19:15]}, 32'd0);
                check("sw_imm7", {26'd0, ia[31:26]}, 32'd0);
            end
            if (va && ia[6:0] == 7'h03) check("lw_imm", {20'd0, ia[31:26], 6'd0}, 32'd0);
        end
        sif_a = 1'b0;
        check("sw_before_commit", sw_early, 0);
        n_tests++;
        if (sw_late == 0) begin
            n_fail++;
            $display("FAIL sw_after_commit: got %0d SW words expected at least 1", sw_late);
        end
        check("accepted_words", exp_q.size(), {16'd0, m_count});

        // Reset while a word is stalled: word dropped, LFSR back to SEED.
        rdy_a = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", {31'd0, va}, 32'd1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", {31'd0, va}, 32'd0);
        check("mid_rst_instr", ia, 32'h7F);
        check("mid_rst_count", {16'd0, ca}, 32'd0);
        check("mid_rst_done", {31'd0, da}, 32'd0);
        rst_a = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", {31'd0, va}, 32'd1);
        check("post_rst_first_word", ia, 32'h8020_0013);

        // Short run with drain, table-driven.
        en_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rdy_b = tbl[i].rdy;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), {31'd0, vb}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].chk_word) check($sformatf("tbl%0d_instr", i), ib, tbl[i].exp_word);
            check($sformatf("tbl%0d_count", i), {16'd0, cb}, {16'd0, tbl[i].exp_count});
            check($sformatf("tbl%0d_done", i), {31'd0, db}, {31'd0, tbl[i].exp_done});
        end
        en_b = 1'b0;

        // MAX_INSTS=0 with DRAIN_NOPS=0: straight to done, no word ever valid.
        en_c = 1'b1; rdy_c = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("zero_valid", {31'd0, vc}, 32'd0);
            check("zero_done", {31'd0, dc}, 32'd1);
            check("zero_count", {16'd0, cc}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
